// File: rtl/ped_pkg.sv
// ped_pkg: shared types and constants for the pedestrian-crossing stage.
//   state_e          - FSM state encoding (IDLE, WAIT_RED, WALK, FLASH)
//   CNT_W            - width of every internal counter
//   LIGHTS_RED_ONLY  - {red, yellow, green} pattern of a vehicle red-only window
//   lamps_red_only() - decodes the vehicle lamp triple against LIGHTS_RED_ONLY
package ped_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LAMP_W = 3;

  localparam logic [LAMP_W-1:0] LIGHTS_RED_ONLY = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RED = 2'd1,
    WALK     = 2'd2,
    FLASH    = 2'd3
  } state_e;

  // True when only the vehicle red lamp is lit.
  function automatic logic lamps_red_only(input logic red, input logic yellow,
                                          input logic green);
    return ({red, yellow, green} == LIGHTS_RED_ONLY);
  endfunction

endpackage

// File: rtl/ped_debounce.sv
// ped_debounce: push-button conditioner for the pedestrian crossing.
//   Two-flop synchroniser, stable-level counter and a one-cycle press pulse
//   raised in the cycle the debounced level rises.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   i_button  - raw, asynchronous push-button
//   o_press   - registered 1-cycle pulse on a debounced 0->1 transition
module ped_debounce
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_button,
  output logic o_press
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Synchronise, then accept a new level only after it has differed from the
  // debounced level for DEBOUNCE_LEN consecutive cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_cnt_inc == CNT_W'(DEBOUNCE_LEN)) begin
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/ped_signal.sv
// ped_signal: pedestrian-crossing stage downstream of the vehicle controller.
//   Latches a debounced crossing request, grants WALK only on a fresh vehicle
//   red-only entry, then runs a flashing DON'T-WALK clearance phase. Leaving
//   red while pedestrians hold right of way aborts to IDLE and sets a sticky
//   conflict flag.
// Optional feature macro: PED_COUNTDOWN_EN (clearance countdown output);
//   when undefined, countdown is tied to 0 and no countdown logic exists.
// Ports:
//   clock, reset                   - clock and asynchronous active-high reset
//   car_red, car_yellow, car_green - vehicle lamp state
//   button                         - raw pedestrian push-button
//   walk, dont_walk                - registered pedestrian lamps
//   req_pending                    - request latched, not yet served
//   conflict                       - sticky vehicle/pedestrian conflict flag
//   countdown                      - remaining clearance cycles
module ped_signal
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LEN = 4,
  parameter int unsigned WALK_LEN     = 4,
  parameter int unsigned FLASH_LEN    = 4,
  parameter int unsigned FLASH_DIV    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             car_red,
  input  logic             car_yellow,
  input  logic             car_green,
  input  logic             button,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic             conflict,
  output logic [CNT_W-1:0] countdown
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_fcnt;
  logic             r_walk;
  logic             r_dont_walk;
  logic             r_req;
  logic             r_conflict;
  logic             r_prev_red_only;

  state_e           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [CNT_W-1:0] w_nxt_fcnt;
  logic             w_nxt_walk;
  logic             w_nxt_dont_walk;
  logic             w_nxt_req;
  logic             w_nxt_conflict;
  logic             w_req_clr;
  logic             w_press;
  logic             w_red_only;
  logic             w_red_entry;

  ped_debounce #(
    .DEBOUNCE_LEN(DEBOUNCE_LEN)
  ) u_debounce (
    .clock   (clock),
    .reset   (reset),
    .i_button(button),
    .o_press (w_press)
  );

  assign w_red_only  = lamps_red_only(car_red, car_yellow, car_green);
  // Only a fresh entry into red-only guarantees a full red window.
  assign w_red_entry = w_red_only & ~r_prev_red_only;

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_fcnt          <= '0;
      r_walk          <= 1'b0;
      r_dont_walk     <= 1'b1;
      r_req           <= 1'b0;
      r_conflict      <= 1'b0;
      r_prev_red_only <= 1'b0;
    end else begin
      r_state         <= w_nxt_state;
      r_cnt           <= w_nxt_cnt;
      r_fcnt          <= w_nxt_fcnt;
      r_walk          <= w_nxt_walk;
      r_dont_walk     <= w_nxt_dont_walk;
      r_req           <= w_nxt_req;
      r_conflict      <= w_nxt_conflict;
      r_prev_red_only <= w_red_only;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_fcnt      = r_fcnt;
    w_nxt_walk      = r_walk;
    w_nxt_dont_walk = r_dont_walk;
    w_nxt_conflict  = r_conflict;
    w_req_clr       = 1'b0;

    case (r_state)
      IDLE: begin
        w_nxt_walk      = 1'b0;
        w_nxt_dont_walk = 1'b1;
        if (r_req) begin
          w_nxt_state = WAIT_RED;
        end
      end

      WAIT_RED: begin
        w_nxt_walk      = 1'b0;
        w_nxt_dont_walk = 1'b1;
        if (w_red_entry) begin
          w_nxt_state     = WALK;
          w_nxt_walk      = 1'b1;
          w_nxt_dont_walk = 1'b0;
          w_nxt_cnt       = CNT_W'(1);
          w_req_clr       = 1'b1;
        end
      end

      WALK: begin
        if (!w_red_only) begin
          // Vehicles left red while pedestrians have right of way.
          w_nxt_state     = IDLE;
          w_nxt_walk      = 1'b0;
          w_nxt_dont_walk = 1'b1;
          w_nxt_conflict  = 1'b1;
          w_nxt_cnt       = '0;
          w_nxt_fcnt      = '0;
        end else if (r_cnt == CNT_W'(WALK_LEN)) begin
          w_nxt_state     = FLASH;
          w_nxt_walk      = 1'b0;
          w_nxt_dont_walk = 1'b1;
          w_nxt_cnt       = CNT_W'(1);
          w_nxt_fcnt      = CNT_W'(1);
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end

      FLASH: begin
        w_nxt_walk = 1'b0;
        if (!w_red_only) begin
          w_nxt_state     = IDLE;
          w_nxt_dont_walk = 1'b1;
          w_nxt_conflict  = 1'b1;
          w_nxt_cnt       = '0;
          w_nxt_fcnt      = '0;
        end else begin
          if (r_fcnt == CNT_W'(FLASH_DIV)) begin
            w_nxt_dont_walk = ~r_dont_walk;
            w_nxt_fcnt      = CNT_W'(1);
          end else begin
            w_nxt_fcnt = r_fcnt + CNT_W'(1);
          end
          // End of clearance overrides any toggle on the same edge.
          if (r_cnt == CNT_W'(FLASH_LEN)) begin
            w_nxt_state     = IDLE;
            w_nxt_dont_walk = 1'b1;
            w_nxt_cnt       = '0;
            w_nxt_fcnt      = '0;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        w_nxt_state     = IDLE;
        w_nxt_walk      = 1'b0;
        w_nxt_dont_walk = 1'b1;
        w_nxt_cnt       = '0;
        w_nxt_fcnt      = '0;
        w_req_clr       = 1'b1;
      end
    endcase

    // Serving a request wins over a coincident new press.
    w_nxt_req = (r_req | w_press) & ~w_req_clr;
  end

`ifdef PED_COUNTDOWN_EN
  logic [CNT_W-1:0] r_countdown;
  logic [CNT_W-1:0] w_nxt_countdown;

  // Derived from the next counter so the output lines up with the state.
  assign w_nxt_countdown = (w_nxt_state == FLASH) ?
                           (CNT_W'(FLASH_LEN) - w_nxt_cnt + CNT_W'(1)) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_countdown <= '0;
    end else begin
      r_countdown <= w_nxt_countdown;
    end
  end

  assign countdown = r_countdown;
`else
  assign countdown = '0;
`endif

  assign walk        = r_walk;
  assign dont_walk   = r_dont_walk;
  assign req_pending = r_req;
  assign conflict    = r_conflict;

endmodule

// File: tb/tb_ped_signal.sv
// tb_ped_signal: directed bench for ped_signal with default parameters
// (DEBOUNCE_LEN=4, WALK_LEN=4, FLASH_LEN=4, FLASH_DIV=2). Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same point.
module tb_ped_signal;

`ifdef PED_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       car_red;
  logic       car_yellow;
  logic       car_green;
  logic       button;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic       conflict;
  logic [7:0] countdown;

  int n_tests;
  int n_fail;

  int exp_dw[5] = '{1, 1, 0, 0, 1};
  int exp_cd[5] = '{4, 3, 2, 1, 0};

  ped_signal dut (
    .clock      (clock),
    .reset      (reset),
    .car_red    (car_red),
    .car_yellow (car_yellow),
    .car_green  (car_green),
    .button     (button),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .conflict   (conflict),
    .countdown  (countdown)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic lamps(input logic r, input logic y, input logic g);
    car_red    = r;
    car_yellow = y;
    car_green  = g;
  endtask

  // Hold the button for n edges, then release it.
  task automatic press(input int n);
    button = 1'b1;
    tick(n);
    button = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    button  = 1'b0;
    lamps(1'b0, 1'b0, 1'b1);
    tick(3);

    // Reset state.
    check("rst_walk", walk, 0);
    check("rst_dont_walk", dont_walk, 1);
    check("rst_req", req_pending, 0);
    check("rst_conflict", conflict, 0);
    check("rst_countdown", countdown, 0);
    reset = 1'b0;
    tick(2);

    // Short 2-cycle glitch must not register.
    press(2);
    tick(8);
    check("glitch_req", req_pending, 0);
    check("glitch_walk", walk, 0);

    // Full request served on the first red entry.
    press(8);
    check("req_latched", req_pending, 1);
    check("req_no_walk_green", walk, 0);
    lamps(1'b1, 1'b0, 1'b0);
    tick();
    check("walk_start", walk, 1);
    check("walk_start_dw", dont_walk, 0);
    check("walk_start_req", req_pending, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("walk_hold", walk, 1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check("flash_walk", walk, 0);
      check("flash_dw", dont_walk, 32'(exp_dw[i]));
      check("flash_cd", countdown, CD_EN ? 32'(exp_cd[i]) : 32'd0);
    end
    check("idle_req", req_pending, 0);
    check("idle_conflict", conflict, 0);

    // Request while already red waits for the next fresh red entry.
    tick(2);
    press(8);
    tick(10);
    check("red_wait_walk", walk, 0);
    check("red_wait_req", req_pending, 1);
    lamps(1'b1, 1'b1, 1'b0);
    tick();
    check("red_wait_110", walk, 0);
    lamps(1'b1, 1'b0, 1'b0);
    tick();
    check("reentry_walk", walk, 1);
    check("reentry_req", req_pending, 0);

    // Abort in the second WALK cycle.
    tick();
    check("abort_pre_walk", walk, 1);
    lamps(1'b1, 1'b1, 1'b0);
    tick();
    check("abort_walk", walk, 0);
    check("abort_dw", dont_walk, 1);
    check("abort_conflict", conflict, 1);
    check("abort_cd", countdown, 0);
    lamps(1'b0, 1'b0, 1'b1);
    tick(4);
    check("conflict_sticky", conflict, 1);
    check("abort_idle_walk", walk, 0);

    // Press accepted during FLASH is served on the following red entry.
    press(8);
    tick(8);
    check("e_req", req_pending, 1);
    lamps(1'b1, 1'b0, 1'b0);
    tick();
    check("e_walk", walk, 1);
    button = 1'b1;
    tick(7);
    button = 1'b0;
    check("e_flash_dw", dont_walk, 0);
    check("e_flash_walk", walk, 0);
    check("e_flash_req", req_pending, 1);
    check("e_flash_cd", countdown, CD_EN ? 32'd1 : 32'd0);
    tick();
    check("e_idle_dw", dont_walk, 1);
    check("e_idle_req", req_pending, 1);
    tick();
    lamps(1'b0, 1'b0, 1'b1);
    tick();
    check("e_green_walk", walk, 0);
    lamps(1'b1, 1'b0, 1'b0);
    tick();
    check("e_serve_walk", walk, 1);
    check("e_serve_req", req_pending, 0);
    tick();

    // Asynchronous reset mid-WALK, checked before the next edge.
    #2;
    reset = 1'b1;
    #1;
    check("areset_walk", walk, 0);
    check("areset_dw", dont_walk, 1);
    check("areset_conflict", conflict, 0);
    check("areset_req", req_pending, 0);
    tick();
    reset = 1'b0;
    tick(2);
    check("post_reset_walk", walk, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
